// File: rtl/spi_slave_regfile_if.sv
// SPI pins, local register-file write port and received-frame outputs of spi_slave_regfile.
// The slave modport is the register file's view; master is the SPI master / local host side.
interface spi_slave_regfile_if;
    logic       SCLK;
    logic       SS;
    logic       MOSI_bit;
    logic       MISO_bit;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       rx_valid;
    logic [2:0] rx_addr;
    logic [7:0] rx_data;
    logic       frame_err;

    modport slave (
        input  SCLK, SS, MOSI_bit, wr_en, wr_addr, wr_data,
        output MISO_bit, rx_valid, rx_addr, rx_data, frame_err
    );

    modport master (
        output SCLK, SS, MOSI_bit, wr_en, wr_addr, wr_data,
        input  MISO_bit, rx_valid, rx_addr, rx_data, frame_err
    );
endinterface

// File: rtl/spi_slave_regfile.sv
// SPI mode-0 slave on an 8x8 register file: cmd byte selects address, data byte is captured, regfile[addr] is returned.
// Pin-to-event latency SYNC_STAGES+1 clocks; no backpressure, local writes accepted every cycle.
module spi_slave_regfile #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] RESET_VAL   = 8'h00
) (
    input logic            clk_50M,
    input logic            reset,
    spi_slave_regfile_if.slave bus
);

    typedef enum logic [1:0] {IDLE, CMD, DATA, FLUSH} state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
    logic       sclk_d, ss_d;
    logic       sclk_s, ss_s, mosi_s;
    logic       sclk_rise, sclk_fall, ss_rise, ss_fall;
    logic [2:0] settle_cnt;
    logic       settled;

    logic [4:0] bit_cnt;
    logic [6:0] rx_sr;
    logic [7:0] rx_byte_nxt;
    logic [7:0] tx_sr;
    logic       miso_q;
    logic [2:0] addr_q;
    logic [2:0] rx_addr_q;
    logic [7:0] rx_data_q;
    logic       rx_valid_q, frame_err_q;
    logic [7:0] regs [0:7];

    logic start, shift, load_tx, done, abort, tx_shift, miso_clr;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign ss_rise   = ss_s & ~ss_d;
    assign ss_fall   = ~ss_s & ss_d;
    // The SS chain resets high, so a select already low at reset release shows up as a
    // falling edge while the chain flushes; ignore edges until the chain has settled.
    assign settled   = (settle_cnt == 3'(SYNC_STAGES + 1));

    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            sclk_sync  <= '0;
            ss_sync    <= '1;
            mosi_sync  <= '0;
            sclk_d     <= 1'b0;
            ss_d       <= 1'b1;
            settle_cnt <= 3'd0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.SCLK};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], bus.SS};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.MOSI_bit};
            sclk_d    <= sclk_s;
            ss_d      <= ss_s;
            if (!settled) settle_cnt <= settle_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        shift     = 1'b0;
        load_tx   = 1'b0;
        done      = 1'b0;
        abort     = 1'b0;
        tx_shift  = 1'b0;
        miso_clr  = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall && settled) begin
                    start     = 1'b1;
                    miso_clr  = 1'b1;
                    state_nxt = CMD;
                end
            end
            CMD: begin
                if (ss_rise) begin
                    abort     = 1'b1;
                    miso_clr  = 1'b1;
                    state_nxt = IDLE;
                end else if (sclk_rise) begin
                    shift = 1'b1;
                    if (bit_cnt == 5'd7) begin
                        load_tx   = 1'b1;
                        state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                // Deselect wins over a coincident SCLK edge so done and abort stay exclusive.
                if (ss_rise) begin
                    abort     = 1'b1;
                    miso_clr  = 1'b1;
                    state_nxt = IDLE;
                end else if (sclk_rise) begin
                    shift = 1'b1;
                    if (bit_cnt == 5'd15) begin
                        done      = 1'b1;
                        state_nxt = FLUSH;
                    end
                end else if (sclk_fall) begin
                    tx_shift = 1'b1;
                end
            end
            FLUSH: begin
                // Last data bit is held until the master's next falling edge.
                miso_clr = sclk_fall | ss_rise;
                if (ss_rise) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rx_byte_nxt = {rx_sr, mosi_s};

    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            bit_cnt     <= 5'd0;
            rx_sr       <= 7'd0;
            tx_sr       <= 8'd0;
            miso_q      <= 1'b0;
            addr_q      <= 3'd0;
            rx_addr_q   <= 3'd0;
            rx_data_q   <= 8'd0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            for (int i = 0; i < 8; i++) regs[i] <= RESET_VAL;
        end else begin
            rx_valid_q  <= done;
            frame_err_q <= abort;

            if (start) begin
                bit_cnt <= 5'd0;
                rx_sr   <= 7'd0;
            end else if (shift) begin
                bit_cnt <= bit_cnt + 5'd1;
                rx_sr   <= rx_byte_nxt[6:0];
            end

            // Write-first: a local write to the address being fetched is forwarded.
            if (load_tx) begin
                addr_q <= rx_byte_nxt[2:0];
                if (bus.wr_en && (bus.wr_addr == rx_byte_nxt[2:0])) tx_sr <= bus.wr_data;
                else                                                 tx_sr <= regs[rx_byte_nxt[2:0]];
            end else if (tx_shift) begin
                tx_sr <= {tx_sr[6:0], 1'b0};
            end

            if (miso_clr)      miso_q <= 1'b0;
            else if (tx_shift) miso_q <= tx_sr[7];

            if (done) begin
                rx_addr_q <= addr_q;
                rx_data_q <= rx_byte_nxt;
            end

            if (bus.wr_en) regs[bus.wr_addr] <= bus.wr_data;
        end
    end

    assign bus.MISO_bit  = miso_q & ~ss_s;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.rx_addr   = rx_addr_q;
    assign bus.rx_data   = rx_data_q;
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Bench for spi_slave_regfile: directed frames plus random frames scored against a register-file model.
module tb_spi_slave_regfile;

    localparam logic [7:0] RV   = 8'hC3;
    localparam int         HALF = 8;

    logic clk_50M = 1'b0;
    logic reset;

    spi_slave_regfile_if bus();

    spi_slave_regfile #(.SYNC_STAGES(2), .RESET_VAL(RV)) dut (
        .clk_50M (clk_50M),
        .reset   (reset),
        .bus     (bus.slave)
    );

    always #10 clk_50M = ~clk_50M;

    int n_pass  = 0;
    int n_total = 0;
    int rv_cnt  = 0;
    int fe_cnt  = 0;
    int both_cnt = 0;

    always @(negedge clk_50M) begin
        rv_cnt   <= rv_cnt + int'(bus.rx_valid);
        fe_cnt   <= fe_cnt + int'(bus.frame_err);
        both_cnt <= both_cnt + int'(bus.rx_valid & bus.frame_err);
    end

    logic [7:0] mregs [8];
    logic [2:0] last_addr;
    logic [7:0] last_data;

    task automatic tick();
        @(posedge clk_50M);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mregs[i] = RV;
        last_addr = 3'd0;
        last_data = 8'd0;
    endtask

    task automatic wr_local(input logic [2:0] a, input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        tick();
        bus.wr_en   = 1'b0;
        mregs[a]    = d;
    endtask

    // Master side of one transfer: nedges SCLK pulses under SS low.
    task automatic frame(input logic [7:0] cmd, input logic [7:0] dat, input int nedges,
                         input int wr_at, input logic [7:0] wd, input int rst_at,
                         output logic [7:0] mb, output logic mcmd, output logic mtail);
        mb   = 8'd0;
        mcmd = 1'b0;
        bus.SS = 1'b0;
        repeat (HALF) tick();
        for (int i = 0; i < nedges; i++) begin
            if (i < 8)       bus.MOSI_bit = cmd[7-i];
            else if (i < 16) bus.MOSI_bit = dat[15-i];
            else             bus.MOSI_bit = 1'b0;
            repeat (HALF) tick();
            if (i < 8)       mcmd = mcmd | bus.MISO_bit;
            else if (i < 16) mb[15-i] = bus.MISO_bit;
            bus.SCLK = 1'b1;
            if (i == wr_at) begin
                tick();
                tick();
                bus.wr_en   = 1'b1;
                bus.wr_addr = cmd[2:0];
                bus.wr_data = wd;
                tick();
                bus.wr_en   = 1'b0;
                mregs[cmd[2:0]] = wd;
                repeat (HALF - 3) tick();
            end else if (i == rst_at) begin
                repeat (HALF) tick();
                reset = 1'b1;
                tick();
                tick();
                check("rst_miso", {31'd0, bus.MISO_bit}, 32'd0);
                check("rst_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
                reset = 1'b0;
                model_reset();
            end else begin
                repeat (HALF) tick();
            end
            bus.SCLK = 1'b0;
        end
        repeat (HALF) tick();
        mtail  = bus.MISO_bit;
        bus.SS = 1'b1;
        repeat (2 * HALF) tick();
        check("idle_miso", {31'd0, bus.MISO_bit}, 32'd0);
    endtask

    // Runs a frame and scores it: a full frame returns regfile[cmd&7] (or the bypassed write)
    // and publishes addr/data; a short one raises frame_err and leaves outputs untouched.
    task automatic frame_chk(input logic [7:0] cmd, input logic [7:0] dat, input int nedges,
                             input int wr_at, input logic [7:0] wd);
        logic [7:0] exp_miso, mb;
        logic       mcmd, mtail, full;
        int         rv0, fe0;
        exp_miso = (wr_at == 7) ? wd : mregs[cmd[2:0]];
        full     = (nedges >= 16);
        rv0 = rv_cnt;
        fe0 = fe_cnt;
        frame(cmd, dat, nedges, wr_at, wd, -1, mb, mcmd, mtail);
        check("rx_valid_pulses", rv_cnt - rv0, {31'd0, full});
        check("frame_err_pulses", fe_cnt - fe0, {31'd0, !full});
        if (full) begin
            check("miso_byte", {24'd0, mb}, {24'd0, exp_miso});
            check("miso_cmd_phase", {31'd0, mcmd}, 32'd0);
            check("miso_flush", {31'd0, mtail}, 32'd0);
            last_addr = cmd[2:0];
            last_data = dat;
        end
        check("rx_addr", {29'd0, bus.rx_addr}, {29'd0, last_addr});
        check("rx_data", {24'd0, bus.rx_data}, {24'd0, last_data});
    endtask

    initial begin
        logic [7:0] mb;
        logic       mcmd, mtail;
        int         rv0, fe0, n;

        bus.SCLK     = 1'b0;
        bus.SS       = 1'b1;
        bus.MOSI_bit = 1'b0;
        bus.wr_en    = 1'b0;
        bus.wr_addr  = 3'd0;
        bus.wr_data  = 8'd0;
        reset        = 1'b1;
        model_reset();
        repeat (4) tick();
        check("reset_miso", {31'd0, bus.MISO_bit}, 32'd0);
        check("reset_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
        check("reset_frame_err", {31'd0, bus.frame_err}, 32'd0);
        check("reset_rx_addr", {29'd0, bus.rx_addr}, 32'd0);
        check("reset_rx_data", {24'd0, bus.rx_data}, 32'd0);
        reset = 1'b0;
        repeat (8) tick();

        // Untouched entry still holds the reset value.
        frame_chk(8'h07, 8'h99, 16, -1, 8'h00);

        for (int a = 0; a < 8; a++) wr_local(3'(a), 8'($urandom));
        wr_local(3'd5, 8'hA7);
        wr_local(3'd2, 8'h81);
        wr_local(3'd4, 8'h11);

        frame_chk(8'h05, 8'h3C, 16, -1, 8'h00);
        frame_chk(8'hFA, 8'($urandom), 16, -1, 8'h00);
        frame_chk(8'h03, 8'h66, 11, -1, 8'h00);
        frame_chk(8'h01, 8'($urandom), 16, -1, 8'h00);
        frame_chk(8'h04, 8'hE1, 16, 7, 8'h5A);
        frame_chk(8'h04, 8'h0F, 16, -1, 8'h00);

        rv0 = rv_cnt;
        fe0 = fe_cnt;
        frame(8'h05, 8'h77, 16, -1, 8'h00, 11, mb, mcmd, mtail);
        repeat (2) tick();
        check("rst_rx_valid_pulses", rv_cnt - rv0, 32'd0);
        check("rst_frame_err_pulses", fe_cnt - fe0, 32'd0);
        check("rst_rx_addr", {29'd0, bus.rx_addr}, 32'd0);
        check("rst_rx_data", {24'd0, bus.rx_data}, 32'd0);
        frame_chk(8'($urandom), 8'($urandom), 16, -1, 8'h00);

        frame_chk(8'h02, 8'hB4, 20, -1, 8'h00);

        for (int f = 0; f < 20; f++) begin
            n = int'($urandom_range(0, 2));
            for (int k = 0; k < n; k++) wr_local(3'($urandom), 8'($urandom));
            case ($urandom_range(0, 3))
                0:       n = int'($urandom_range(1, 15));
                1:       n = int'($urandom_range(17, 24));
                default: n = 16;
            endcase
            frame_chk(8'($urandom), 8'($urandom), n, -1, 8'h00);
        end

        check("valid_and_err_together", both_cnt, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/spi_slave_regfile.md
SPI_SLAVE_REGFILE -- requirements
Module: spi_slave_regfile

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of flip-flop stages synchronising SCLK, SS and MOSI_bit into the clk_50M domain (legal 2..3).
REQ-002 Parameter RESET_VAL, default 8'h00, value loaded into all eight register-file entries on reset.
REQ-003 clk_50M  input  1  sole system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 SCLK  input  1  serial clock from master, asynchronous to clk_50M, idle low.
REQ-006 SS  input  1  active-low slave select from master.
REQ-007 MOSI_bit  input  1  serial data from master, MSB first.
REQ-008 MISO_bit  output  1  serial data to master, MSB first.
REQ-009 wr_en  input  1  local register-file write strobe.
REQ-010 wr_addr  input  3  local write address.
REQ-011 wr_data  input  8  local write data.
REQ-012 rx_valid  output  1  one-cycle pulse: complete 16-bit frame received.
REQ-013 rx_addr  output  3  address field of last complete frame.
REQ-014 rx_data  output  8  second (data) byte of last complete frame.
REQ-015 frame_err  output  1  one-cycle pulse: SS deasserted before 16 SCLK rising edges.

Function
REQ-016 SCLK, SS, MOSI_bit shall each pass through SYNC_STAGES flops; edges shall be detected by comparing the last synchronised stage against one further registered copy, giving SYNC_STAGES+1 cycles pin-to-event latency.
REQ-017 Frame format: 16 SCLK cycles under SS low; byte 0 is command (bits [2:0] = address, bits [7:3] ignored); byte 1 is data.
REQ-018 MOSI_bit shall be sampled on each synchronised SCLK rising edge; MISO_bit shall change only on synchronised SCLK falling edges or SS transitions.
REQ-019 State machine states: IDLE, CMD, DATA, FLUSH.
REQ-020 IDLE -> CMD on synchronised SS falling edge; bit counter cleared to 0, receive shift register cleared.
REQ-021 CMD: each SCLK rising edge shifts MOSI into receive register and increments 5-bit bit counter; MISO_bit held 0.
REQ-022 On the 8th rising edge (counter 7->8): address latched from received bits [2:0]; transmit register loaded with regfile[address]; state -> DATA.
REQ-023 DATA: first SCLK falling edge after entry drives MISO_bit = tx[7]; each subsequent falling edge shifts tx left, driving next bit; rising edges continue capturing MOSI.
REQ-024 On 16th rising edge: rx_addr <= latched address, rx_data <= received byte 1, rx_valid pulses for exactly one cycle; state -> FLUSH.
REQ-025 FLUSH: further SCLK edges ignored, MISO_bit held 0; synchronised SS rising edge -> IDLE with no frame_err.
REQ-026 Synchronised SS rising edge in CMD or DATA: frame_err pulses one cycle, rx_addr/rx_data/rx_valid unchanged, state -> IDLE.
REQ-027 SS falling edge while in FLUSH or during an aborted frame is only acted on from IDLE; SS low at reset release does not start a frame until a falling edge is seen.
REQ-028 MISO_bit shall be 0 whenever SS (synchronised) is high.
REQ-029 Register file: 8 x 8; wr_en writes wr_data to wr_addr on clock edge; local writes allowed at any time.
REQ-030 Write in same cycle as the REQ-022 load to the same address: transmit register shall receive wr_data (write-first bypass).
REQ-031 SCLK edges while in IDLE shall have no effect.
REQ-032 rx_valid and frame_err shall never assert in the same cycle.

Reset
REQ-033 While reset high: state IDLE, counter 0, shift registers 0, synchroniser flops 0 except SS chain 1, all regfile entries RESET_VAL, MISO_bit 0, rx_valid 0, rx_addr 0, rx_data 0, frame_err 0.
REQ-034 Reset asserted mid-frame shall abort without frame_err pulse; the frame is discarded.

Verification
REQ-035 Preload regfile[5]=8'hA7; frame cmd 8'h05, data 8'h3C -> MISO bits 10100111 in byte 1, rx_valid one cycle, rx_addr=5, rx_data=8'h3C.
REQ-036 Cmd 8'hFA (address 2) with regfile[2]=8'h81 -> MISO returns 8'h81, rx_addr=2 (upper bits ignored).
REQ-037 SS raised after 11 SCLK edges -> frame_err one cycle, rx_valid 0, rx_addr/rx_data retain previous values; next full frame completes normally.
REQ-038 wr_en to address 4 with 8'h5A in the exact cycle of the 8th rising edge of a cmd-4 frame -> MISO returns 8'h5A.
REQ-039 Reset pulsed during DATA phase -> MISO_bit 0, no rx_valid/frame_err, regfile reads RESET_VAL; subsequent frame returns RESET_VAL.
REQ-040 Extra SCLK pulses (20 total) with SS low -> single rx_valid after 16th edge, MISO 0 after, no frame_err on SS release.
